// File: rtl/serial_word_tx_if.sv
// Handshake bundle between the FIR output stage, serial_word_tx and the downstream serial receiver.
interface serial_word_tx_if #(
   parameter int DATA_WIDTH = 24,
   parameter int FIFO_DEPTH = 4
);
   logic [DATA_WIDTH-1:0]         i_word;
   logic                          i_word_valid;
   logic                          o_word_ready;
   logic                          o_dout;
   logic                          o_dout_valid;
   logic                          i_ready;
   logic [$clog2(FIFO_DEPTH):0]   o_fifo_count;

   modport master (
      output i_word, i_word_valid, i_ready,
      input  o_word_ready, o_dout, o_dout_valid, o_fifo_count
   );

   modport slave (
      input  i_word, i_word_valid, i_ready,
      output o_word_ready, o_dout, o_dout_valid, o_fifo_count
   );
endinterface

// File: rtl/serial_word_tx.sv
// Parallel-to-serial transmitter: small word FIFO feeding an LSB-first shifter with a
// mandatory low gap on o_dout_valid between words.
module serial_word_tx #(
   parameter int DATA_WIDTH = 24,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_en,
   serial_word_tx_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(DATA_WIDTH);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
   logic                  valid_q, valid_d;
   logic                  full_s, empty_s, push_s, pop_s;

   // Push acceptance uses only the registered count, so a same-edge pop never frees a slot.
   always_comb begin
      full_s  = (count_q == CW'(FIFO_DEPTH));
      empty_s = (count_q == {CW{1'b0}});
      push_s  = i_en & bus.i_word_valid & ~full_s;
      pop_s   = i_en & (state_q == ST_IDLE) & ~empty_s;
   end

   // FIFO pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Shifter FSM next-state; nothing moves while i_en is low.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      valid_d   = valid_q;
      case (state_q)
         ST_IDLE: begin
            if (pop_s) begin
               shift_d   = mem_q[rd_ptr_q];
               bit_cnt_d = {BW{1'b0}};
               valid_d   = 1'b1;
               state_d   = ST_SHIFT;
            end else begin
               valid_d   = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (i_en && bus.i_ready) begin
               if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                  valid_d   = 1'b0;
                  gap_cnt_d = {GW{1'b0}};
                  state_d   = ST_GAP;
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_GAP: begin
            valid_d = 1'b0;
            if (!i_en) begin
               state_d = ST_GAP;
            end else if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // FIFO storage; contents are don't-care once the pointers are reset.
   always_ff @(posedge i_clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= bus.i_word;
      end
   end

   // Control and datapath registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q  <= {AW{1'b0}};
         rd_ptr_q  <= {AW{1'b0}};
         count_q   <= {CW{1'b0}};
         state_q   <= ST_IDLE;
         shift_q   <= {DATA_WIDTH{1'b0}};
         bit_cnt_q <= {BW{1'b0}};
         gap_cnt_q <= {GW{1'b0}};
         valid_q   <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         valid_q   <= valid_d;
      end
   end

   assign bus.o_word_ready = ~full_s;
   assign bus.o_fifo_count = count_q;
   assign bus.o_dout_valid = valid_q;
   assign bus.o_dout       = valid_q & shift_q[0];
endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: stimulus queues expected words, monitors reassemble
// the serial stream and compare against the queue.
module tb_serial_word_tx;
   localparam int DW = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp_g [$];
   int            bitk   = 0;
   int            bitk_g = 0;

   serial_word_tx_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) bus ();
   serial_word_tx_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) gbus ();

   serial_word_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .GAP_CYCLES(1)) dut (
      .i_clk (clk), .i_rst (rst), .i_en (en), .bus (bus.slave)
   );
   serial_word_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .GAP_CYCLES(3)) dut_g (
      .i_clk (clk), .i_rst (rst), .i_en (1'b1), .bus (gbus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [DW-1:0] w, input logic acc);
      bus.i_word       = w;
      bus.i_word_valid = 1'b1;
      chk("word_ready", {31'd0, bus.o_word_ready}, {31'd0, acc});
      if (acc) exp_q.push_back(w);
      step(1);
      bus.i_word_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || bitk != 0) && n < budget) begin
         step(1);
         n++;
      end
      chk("drain", exp_q.size(), 32'd0);
   endtask

   // Monitor for the GAP_CYCLES=1 instance: reassembly, zero-when-invalid and hold-on-stall.
   initial begin
      logic [DW-1:0] asm_w;
      logic          prev_hold = 1'b0;
      logic          prev_bit  = 1'b0;
      logic [DW-1:0] w;
      asm_w = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bitk      = 0;
            prev_hold = 1'b0;
         end else begin
            if (!bus.o_dout_valid) chk("dout_zero_when_invalid", {31'd0, bus.o_dout}, 32'd0);
            if (prev_hold && bus.o_dout_valid) chk("bit_hold", {31'd0, bus.o_dout}, {31'd0, prev_bit});
            prev_hold = bus.o_dout_valid && !(en && bus.i_ready);
            prev_bit  = bus.o_dout;
            if (bus.o_dout_valid && en && bus.i_ready) begin
               asm_w[bitk] = bus.o_dout;
               bitk++;
               if (bitk == DW) begin
                  bitk = 0;
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_word: got %0h expected none", asm_w);
                  end else begin
                     w = exp_q.pop_front();
                     chk("word", {8'd0, asm_w}, {8'd0, w});
                  end
               end
            end
         end
      end
   end

   // Monitor for the GAP_CYCLES=3 instance: word reassembly only.
   initial begin
      logic [DW-1:0] asm_g;
      logic [DW-1:0] w;
      asm_g = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bitk_g = 0;
         end else if (gbus.o_dout_valid && gbus.i_ready) begin
            asm_g[bitk_g] = gbus.o_dout;
            bitk_g++;
            if (bitk_g == DW) begin
               bitk_g = 0;
               if (exp_g.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word_g: got %0h expected none", asm_g);
               end else begin
                  w = exp_g.pop_front();
                  chk("word_g", {8'd0, asm_g}, {8'd0, w});
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hc;
      int low;
      bus.i_word        = '0;
      bus.i_word_valid  = 1'b0;
      bus.i_ready       = 1'b1;
      gbus.i_word       = '0;
      gbus.i_word_valid = 1'b0;
      gbus.i_ready      = 1'b1;
      step(2);
      chk("rst_dout",       {31'd0, bus.o_dout},       32'd0);
      chk("rst_dout_valid", {31'd0, bus.o_dout_valid}, 32'd0);
      chk("rst_word_ready", {31'd0, bus.o_word_ready}, 32'd1);
      chk("rst_fifo_count", {29'd0, bus.o_fifo_count}, 32'd0);
      rst = 1'b0;
      step(1);

      // single word, latency and valid duration
      push(24'hA5C3F0, 1'b1);
      chk("lat_valid_n",  {31'd0, bus.o_dout_valid}, 32'd0);
      chk("lat_count_n",  {29'd0, bus.o_fifo_count}, 32'd1);
      step(1);
      chk("lat_valid_n1", {31'd0, bus.o_dout_valid}, 32'd1);
      chk("lat_bit0",     {31'd0, bus.o_dout},       32'd0);
      hc = 1;
      step(1);
      while (bus.o_dout_valid && hc < 100) begin
         hc++;
         step(1);
      end
      chk("valid_len", hc, 32'd24);
      chk("valid_low_after", {31'd0, bus.o_dout_valid}, 32'd0);
      drain(50);

      // FIFO fill with downstream stalled
      bus.i_ready = 1'b0;
      push(24'h000001, 1'b1);
      push(24'h000002, 1'b1);
      push(24'h000003, 1'b1);
      push(24'h000004, 1'b1);
      push(24'h000005, 1'b1);
      chk("fill_count", {29'd0, bus.o_fifo_count}, 32'd4);
      push(24'h000006, 1'b0);
      chk("fill_count_after_refuse", {29'd0, bus.o_fifo_count}, 32'd4);
      bus.i_ready = 1'b1;
      drain(1000);
      step(40);
      chk("fill_empty_count", {29'd0, bus.o_fifo_count}, 32'd0);
      chk("fill_idle_valid",  {31'd0, bus.o_dout_valid}, 32'd0);

      // stall at bit 11
      push(24'hFFF000, 1'b1);
      step(12);
      chk("stall_bit11", {31'd0, bus.o_dout}, 32'd0);
      bus.i_ready = 1'b0;
      repeat (3) begin
         step(1);
         chk("stall_hold_bit",   {31'd0, bus.o_dout},       32'd0);
         chk("stall_hold_valid", {31'd0, bus.o_dout_valid}, 32'd1);
      end
      bus.i_ready = 1'b1;
      drain(100);

      // enable freeze at bit 7 with a push attempt
      push(24'h5A5AD5, 1'b1);
      step(8);
      chk("freeze_bit7", {31'd0, bus.o_dout}, 32'd1);
      en               = 1'b0;
      bus.i_word       = 24'h111111;
      bus.i_word_valid = 1'b1;
      repeat (5) begin
         step(1);
         chk("freeze_bit",   {31'd0, bus.o_dout},       32'd1);
         chk("freeze_count", {29'd0, bus.o_fifo_count}, 32'd0);
      end
      en               = 1'b1;
      bus.i_word_valid = 1'b0;
      drain(100);
      step(5);
      chk("freeze_no_push", {29'd0, bus.o_fifo_count}, 32'd0);

      // reset at bit 10 with two words queued
      push(24'h0F0F0F, 1'b1);
      push(24'h222222, 1'b1);
      push(24'h333333, 1'b1);
      step(9);
      chk("rstmid_count", {29'd0, bus.o_fifo_count}, 32'd2);
      rst = 1'b1;
      exp_q.delete();
      step(1);
      chk("rstmid_valid", {31'd0, bus.o_dout_valid}, 32'd0);
      chk("rstmid_count0", {29'd0, bus.o_fifo_count}, 32'd0);
      chk("rstmid_ready", {31'd0, bus.o_word_ready}, 32'd1);
      rst = 1'b0;
      step(1);
      push(24'h123456, 1'b1);
      drain(100);

      // GAP_CYCLES=3 instance: two back-to-back words
      gbus.i_word       = 24'h00000F;
      gbus.i_word_valid = 1'b1;
      exp_g.push_back(24'h00000F);
      step(1);
      gbus.i_word = 24'hF00000;
      exp_g.push_back(24'hF00000);
      step(1);
      gbus.i_word_valid = 1'b0;
      n = 0;
      while (!gbus.o_dout_valid && n < 50) begin
         n++;
         step(1);
      end
      n = 0;
      while (gbus.o_dout_valid && n < 100) begin
         n++;
         step(1);
      end
      low = 0;
      while (!gbus.o_dout_valid && low < 50) begin
         low++;
         step(1);
      end
      chk("gap_len", low, 32'd4);
      n = 0;
      while ((exp_g.size() != 0 || bitk_g != 0) && n < 100) begin
         n++;
         step(1);
      end
      chk("drain_g", exp_g.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
